mem_read_align: RTL and testbench
=================================

Name: mem_read_align

Overview:
- Load path of the data-memory interface; the read-side counterpart of the store aligner.
- Accepts one load request at a time from execute and issues a word-aligned read to data memory.
- Waits a variable latency for the response, then extracts the byte, halfword or word, sign- or zero-extends it, and returns it to writeback with a ready/valid handshake.
- Flags misaligned loads and illegal formats as alignment exceptions without touching memory.

Parameters:
- TAG_W, 5: width of the destination tag (rd) carried from request to response.

Ports:
- clk  input  1  clock.
- rst  input  1  reset, asynchronous, active-high.
- req_valid  input  1  load request valid.
- req_ready  output  1  block can accept a request.
- req_addr  input  32  byte address.
- req_format  input  3  RISC-V load funct3: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
- req_tag  input  TAG_W  destination tag, passed through unchanged.
- mem_req  output  1  memory read request.
- mem_addr  output  32  word address; bits [1:0] are always 0.
- mem_gnt  input  1  memory accepted mem_req this cycle.
- mem_rvalid  input  1  read data valid.
- mem_rdata  input  32  read word, little-endian.
- rsp_valid  output  1  response valid.
- rsp_ready  input  1  writeback accepts the response.
- rsp_data  output  32  aligned, extended load data.
- rsp_tag  output  TAG_W  tag of the request.
- rsp_except  output  1  alignment or format exception.

Behaviour:
- Reset (rst=1, asynchronous): state IDLE. All outputs 0 except req_ready=1. Any capture registers cleared.
- req_ready = (state==IDLE). A request transfers on req_valid & req_ready; addr, format and tag are registered.
- Exception check at accept:
  - LH/LHU with addr[0]=1 raises an exception.
  - LW with addr[1:0]!=0 raises an exception.
  - Formats 011, 110 and 111 always raise an exception.
  - On exception: go directly to RESP with rsp_except=1, rsp_data=0. No mem_req is issued.
- States:
  - IDLE -> REQ on a valid, non-excepting request.
  - REQ: mem_req=1, mem_addr={addr[31:2],2'b00}, both held stable until mem_gnt. On mem_gnt -> WAIT.
  - WAIT: mem_req=0. On mem_rvalid, capture the extracted data -> RESP.
  - RESP: rsp_valid=1; rsp_data/tag/except held stable until rsp_ready -> IDLE.
- Memory protocol:
  - One read outstanding at a time.
  - mem_rvalid arrives at least 1 cycle after mem_gnt.
  - mem_rvalid in any state other than WAIT (or WAIT2) is ignored.
- Extraction: byte b = mem_rdata[8*off+7 : 8*off], where off=addr[1:0]; halfword = mem_rdata[16*addr[1]+15 : 16*addr[1]].
  - LB/LH sign-extend to 32 bits.
  - LBU/LHU zero-extend to 32 bits.
  - LW passes the word unchanged.
- Latency, with mem_gnt in the first REQ cycle and mem_rvalid 1 cycle later:
  - accept at cycle 0; mem_req at cycle 1; rvalid at cycle 2; rsp_valid at cycle 3.
  - An exception response is rsp_valid at cycle 1.
- No new request is accepted in the cycle that RESP completes; req_ready rises the following cycle.
- Reset mid-operation: abort immediately, return to IDLE. A stale mem_rvalid arriving after reset is ignored.

Optional Feature:
- Macro: MISALIGNED_LOAD_EN.
- When defined, the following no longer raise an exception:
  - LH/LHU at off=1 is a single access (bytes 1–2).
  - LH/LHU at off=3 and LW at off 1/2/3 cross a word boundary.
- Crossing loads use two extra states:
  - REQ/WAIT read the low word at {addr[31:2],00}.
  - REQ2/WAIT2 then read the high word at low address + 4, with 32-bit wrap at 0xFFFFFFFC -> 0x00000000.
  - Result = low 32 bits of ({hi,lo} >> 8*off), then extended per format.
- Illegal formats still raise an exception.
- When not defined, the exception rules above apply unchanged, and states REQ2/WAIT2 do not exist.

Test Plan:
- Memory word at 0x100 = 0x8899AABB:
  - LB 0x101 -> rsp_data 0xFFFFFFAA.
  - LBU 0x103 -> 0x00000088.
  - LH 0x102 -> 0xFFFF8899.
  - LHU 0x100 -> 0x0000AABB.
  - In all four cases mem_addr=0x100 and rsp_except=0.
- LW 0x102 (macro off) -> rsp_valid 1 cycle after accept, rsp_except=1, rsp_data=0, mem_req never asserted; format 011 gives the same response.
- mem_gnt delayed 4 cycles, then mem_rvalid 3 cycles later -> mem_req/mem_addr stable throughout REQ; rsp_valid exactly 1 cycle after rvalid; rsp_tag=0x1F equals req_tag.
- rsp_ready held low 3 cycles -> rsp_valid/data/tag stable; req_ready=0 until the cycle after the handshake.
- rst asserted during WAIT, then mem_rvalid pulsed -> outputs 0, req_ready=1, no rsp_valid.
- (MISALIGNED_LOAD_EN) 0x100=0x8899AABB, 0x104=0x11223344:
  - LW 0x102 -> two reads (0x100 then 0x104), rsp_data 0x33448899.
  - LH 0x103 -> 0x00004488.

Source files
------------

// File: rtl/mem_read_align.sv
// mem_read_align: load path of the data-memory interface.
// Takes one load at a time, issues a word-aligned read, then extracts the
// byte/halfword/word, sign- or zero-extends it and hands it to writeback.
// Misaligned loads and illegal funct3 values come back as alignment
// exceptions without any memory access.
// Build option: define MISALIGNED_LOAD_EN to accept misaligned halfword and
// word loads. Loads that straddle a word boundary then take a second read.
module mem_read_align #(
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [31:0]      req_addr,
    input  logic [2:0]       req_format,
    input  logic [TAG_W-1:0] req_tag,
    output logic             mem_req,
    output logic [31:0]      mem_addr,
    input  logic             mem_gnt,
    input  logic             mem_rvalid,
    input  logic [31:0]      mem_rdata,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [31:0]      rsp_data,
    output logic [TAG_W-1:0] rsp_tag,
    output logic             rsp_except
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        REQ   = 3'd1,
        WAIT  = 3'd2,
        RESP  = 3'd3
`ifdef MISALIGNED_LOAD_EN
        ,
        REQ2  = 3'd4,
        WAIT2 = 3'd5
`endif
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic [31:0]       addr_q;
    logic [2:0]        fmt_q;
    logic [TAG_W-1:0]  tag_q;
    logic [31:0]       data_q;
    logic              except_q;
    logic              accept_exc;
    logic [31:0]       word_addr;

    assign word_addr  = {addr_q[31:2], 2'b00};
    assign rsp_data   = data_q;
    assign rsp_tag    = tag_q;
    assign rsp_except = except_q;

    // funct3 values 011, 110 and 111 are not loads in any configuration
    function automatic logic fmt_illegal(input logic [2:0] fmt);
        return (fmt == 3'b011) || (fmt[2:1] == 2'b11);
    endfunction

    // Shift the {hi,lo} byte window down by the byte offset, then extend.
    // Only the low 24 bits of hi can ever reach the result.
    function automatic logic [31:0] align_extend(input logic [23:0] hi,
                                                 input logic [31:0] lo,
                                                 input logic [1:0]  off,
                                                 input logic [2:0]  fmt);
        logic [31:0] s;
        case (off)
            2'd0:    s = lo;
            2'd1:    s = {hi[7:0],  lo[31:8]};
            2'd2:    s = {hi[15:0], lo[31:16]};
            default: s = {hi[23:0], lo[31:24]};
        endcase
        case (fmt[1:0])
            2'b00:   return {{24{~fmt[2] & s[7]}},  s[7:0]};
            2'b01:   return {{16{~fmt[2] & s[15]}}, s[15:0]};
            default: return s;
        endcase
    endfunction

`ifdef MISALIGNED_LOAD_EN
    logic crossing;

    // A load crosses into the next word when its last byte lies past offset 3
    always_comb begin
        crossing = ((fmt_q[1:0] == 2'b01) && (addr_q[1:0] == 2'b11)) ||
                   ((fmt_q[1:0] == 2'b10) && (addr_q[1:0] != 2'b00));
    end
`endif

    // Decide at accept time whether the incoming load must be refused
    always_comb begin
        accept_exc = fmt_illegal(req_format);
`ifndef MISALIGNED_LOAD_EN
        if ((req_format[1:0] == 2'b01) && req_addr[0]) begin
            accept_exc = 1'b1;
        end
        if ((req_format[1:0] == 2'b10) && (req_addr[1:0] != 2'b00)) begin
            accept_exc = 1'b1;
        end
`endif
    end

    // State register; reset aborts any load in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and handshake outputs, all derived from the current state
    always_comb begin
        state_d   = state_q;
        req_ready = 1'b0;
        mem_req   = 1'b0;
        mem_addr  = 32'h0;
        rsp_valid = 1'b0;
        case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    state_d = accept_exc ? RESP : REQ;
                end
            end
            REQ: begin
                mem_req  = 1'b1;
                mem_addr = word_addr;
                if (mem_gnt) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (mem_rvalid) begin
`ifdef MISALIGNED_LOAD_EN
                    state_d = crossing ? REQ2 : RESP;
`else
                    state_d = RESP;
`endif
                end
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
`ifdef MISALIGNED_LOAD_EN
            REQ2: begin
                mem_req  = 1'b1;
                mem_addr = word_addr + 32'd4;
                if (mem_gnt) begin
                    state_d = WAIT2;
                end
            end
            WAIT2: begin
                if (mem_rvalid) begin
                    state_d = RESP;
                end
            end
`endif
            default: begin
                state_d = IDLE;
            end
        endcase
    end

`ifdef MISALIGNED_LOAD_EN
    logic [31:0] lo_q;

    // Low word of a boundary-crossing load, held while the high word is read
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lo_q <= 32'h0;
        end else if ((state_q == WAIT) && mem_rvalid && crossing) begin
            lo_q <= mem_rdata;
        end
    end
`endif

    // Request capture at accept and result capture when read data returns
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q   <= 32'h0;
            fmt_q    <= 3'b000;
            tag_q    <= '0;
            data_q   <= 32'h0;
            except_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        addr_q   <= req_addr;
                        fmt_q    <= req_format;
                        tag_q    <= req_tag;
                        except_q <= accept_exc;
                        data_q   <= 32'h0;
                    end
                end
                WAIT: begin
`ifdef MISALIGNED_LOAD_EN
                    if (mem_rvalid && !crossing) begin
`else
                    if (mem_rvalid) begin
`endif
                        data_q <= align_extend(24'h0, mem_rdata, addr_q[1:0], fmt_q);
                    end
                end
`ifdef MISALIGNED_LOAD_EN
                WAIT2: begin
                    if (mem_rvalid) begin
                        data_q <= align_extend(mem_rdata[23:0], lo_q, addr_q[1:0], fmt_q);
                    end
                end
`endif
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_read_align.sv
// tb_mem_read_align: table vectors, hand sequences and random loads for
// mem_read_align, checked against a byte-level reference model.
// Build option: MISALIGNED_LOAD_EN selects the misaligned-load expectations.
module tb_mem_read_align;

    localparam int TAG_W = 5;
    localparam logic [31:0] W0 = 32'h8899AABB;
    localparam logic [31:0] W1 = 32'h11223344;

    logic             clk;
    logic             rst;
    logic             req_valid;
    logic             req_ready;
    logic [31:0]      req_addr;
    logic [2:0]       req_format;
    logic [TAG_W-1:0] req_tag;
    logic             mem_req;
    logic [31:0]      mem_addr;
    logic             mem_gnt;
    logic             mem_rvalid;
    logic [31:0]      mem_rdata;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [31:0]      rsp_data;
    logic [TAG_W-1:0] rsp_tag;
    logic             rsp_except;

    int assert_count = 0;
    int fail_count   = 0;

    typedef struct {
        logic [31:0]      addr;
        logic [2:0]       fmt;
        logic [TAG_W-1:0] tag;
        logic [31:0]      lo;
        logic [31:0]      hi;
        int               g;
        int               r;
        int               rdy;
        logic [31:0]      exp_data;
        logic             exp_exc;
    } vec_t;

    vec_t vecs[$];

    mem_read_align #(.TAG_W(TAG_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_addr   (req_addr),
        .req_format (req_format),
        .req_tag    (req_tag),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_gnt    (mem_gnt),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data   (rsp_data),
        .rsp_tag    (rsp_tag),
        .rsp_except (rsp_except)
    );

    // Free-running clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        assert_count++;
        if (actual !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    function automatic int fmtSize(input logic [2:0] fmt);
        case (fmt)
            3'b000, 3'b100: return 1;
            3'b001, 3'b101: return 2;
            3'b010:         return 4;
            default:        return 0;
        endcase
    endfunction

    // Reference: treat lo/hi as eight consecutive little-endian bytes
    function automatic void modelLoad(input logic [31:0] addr, input logic [2:0] fmt,
                                      input logic [31:0] lo, input logic [31:0] hi,
                                      output logic [31:0] data, output logic exc,
                                      output int nreads);
        logic [7:0]  mem [8];
        int          size;
        int          off;
        logic [31:0] v;
        for (int i = 0; i < 4; i++) begin
            mem[i]     = lo[8*i +: 8];
            mem[4 + i] = hi[8*i +: 8];
        end
        size   = fmtSize(fmt);
        off    = int'(addr[1:0]);
        data   = 32'h0;
        exc    = 1'b0;
        nreads = 0;
        if (size == 0) begin
            exc = 1'b1;
            return;
        end
`ifndef MISALIGNED_LOAD_EN
        if ((off % size) != 0) begin
            exc = 1'b1;
            return;
        end
`endif
        v = 32'h0;
        for (int i = 0; i < size; i++) begin
            v = v | (32'(mem[off + i]) << (8 * i));
        end
        if (!fmt[2] && size < 4 && v[8*size-1]) begin
            v = v | (32'hFFFFFFFF << (8 * size));
        end
        data   = v;
        nreads = (off + size > 4) ? 2 : 1;
    endfunction

    // One full load: request, memory responder with given delays, response stall
    task automatic applyStimulus(input logic [31:0] addr, input logic [2:0] fmt,
                                 input logic [TAG_W-1:0] tag,
                                 input logic [31:0] lo, input logic [31:0] hi,
                                 input int g, input int r, input int rdy,
                                 output logic [31:0] data, output logic exc,
                                 output logic [TAG_W-1:0] rtag, output int lat,
                                 output int reads, output logic [31:0] a0,
                                 output logic [31:0] a1, output int unstable,
                                 output logic rr_after, output logic rv_after,
                                 output logic timeout);
        int          gcnt;
        int          rcnt;
        logic [31:0] held;
        reads = 0; a0 = 32'h0; a1 = 32'h0; unstable = 0; timeout = 1'b0;
        lat = 0; gcnt = 0; rcnt = -1; held = 32'h0;
        data = 32'h0; exc = 1'b0; rtag = '0; rr_after = 1'b0; rv_after = 1'b1;
        for (int i = 0; i < 20 && !req_ready; i++) @(negedge clk);
        req_valid  = 1'b1;
        req_addr   = addr;
        req_format = fmt;
        req_tag    = tag;
        @(negedge clk);
        req_valid  = 1'b0;
        req_addr   = $urandom;
        req_format = 3'($urandom);
        req_tag    = TAG_W'($urandom);
        lat = 1;
        while (!rsp_valid && lat < 300) begin
            mem_gnt    = 1'b0;
            mem_rvalid = 1'b0;
            mem_rdata  = $urandom;
            if (mem_req) begin
                if (gcnt == 0) begin
                    held = mem_addr;
                    if (reads == 0) a0 = mem_addr;
                    else a1 = mem_addr;
                end else if (mem_addr !== held) begin
                    unstable++;
                end
                if (gcnt == g) begin
                    mem_gnt = 1'b1;
                    gcnt = 0;
                    rcnt = 0;
                    reads++;
                end else begin
                    gcnt++;
                end
            end else if (rcnt >= 0) begin
                rcnt++;
                if (rcnt == r) begin
                    mem_rvalid = 1'b1;
                    mem_rdata  = (reads == 1) ? lo : hi;
                    rcnt = -1;
                end
            end
            @(negedge clk);
            lat++;
        end
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b0;
        if (!rsp_valid) begin
            timeout = 1'b1;
            return;
        end
        data = rsp_data;
        exc  = rsp_except;
        rtag = rsp_tag;
        for (int i = 0; i < rdy; i++) begin
            rsp_ready = 1'b0;
            if (!rsp_valid || rsp_data !== data || rsp_except !== exc ||
                rsp_tag !== rtag || req_ready || mem_req) unstable++;
            @(negedge clk);
        end
        if (!rsp_valid || rsp_data !== data || req_ready) unstable++;
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        rr_after  = req_ready;
        rv_after  = rsp_valid;
    endtask

    // Run one load and compare everything observable against expectations
    task automatic run_case(input string name, input logic [31:0] addr, input logic [2:0] fmt,
                            input logic [TAG_W-1:0] tag, input logic [31:0] lo,
                            input logic [31:0] hi, input int g, input int r, input int rdy,
                            input logic [31:0] exp_data, input logic exp_exc,
                            input int exp_reads);
        logic [31:0]      data;
        logic             exc;
        logic [TAG_W-1:0] rtag;
        int               lat;
        int               reads;
        logic [31:0]      a0;
        logic [31:0]      a1;
        int               unstable;
        logic             rr_after;
        logic             rv_after;
        logic             timeout;
        int               exp_lat;
        applyStimulus(addr, fmt, tag, lo, hi, g, r, rdy, data, exc, rtag, lat, reads,
                      a0, a1, unstable, rr_after, rv_after, timeout);
        checkOutput($sformatf("%s.timeout", name), 32'(timeout), 32'd0);
        exp_lat = exp_exc ? 1 : 1 + exp_reads * (g + r + 1);
        checkOutput($sformatf("%s.data", name), data, exp_data);
        checkOutput($sformatf("%s.except", name), 32'(exc), 32'(exp_exc));
        checkOutput($sformatf("%s.tag", name), 32'(rtag), 32'(tag));
        checkOutput($sformatf("%s.latency", name), 32'(lat), 32'(exp_lat));
        checkOutput($sformatf("%s.reads", name), 32'(reads), 32'(exp_reads));
        if (exp_reads >= 1) begin
            checkOutput($sformatf("%s.addr0", name), a0, {addr[31:2], 2'b00});
        end
        if (exp_reads == 2) begin
            checkOutput($sformatf("%s.addr1", name), a1, {addr[31:2], 2'b00} + 32'd4);
        end
        checkOutput($sformatf("%s.stable", name), 32'(unstable), 32'd0);
        checkOutput($sformatf("%s.req_ready_after", name), 32'(rr_after), 32'd1);
        checkOutput($sformatf("%s.rsp_valid_after", name), 32'(rv_after), 32'd0);
    endtask

    function automatic void add_vec(input logic [31:0] addr, input logic [2:0] fmt,
                                    input logic [TAG_W-1:0] tag, input int g, input int r,
                                    input int rdy, input logic [31:0] exp_data,
                                    input logic exp_exc);
        vec_t v;
        v = '{addr, fmt, tag, W0, W1, g, r, rdy, exp_data, exp_exc};
        vecs.push_back(v);
    endfunction

    initial begin
        logic [31:0] m_data;
        logic        m_exc;
        int          m_reads;
        logic [31:0] addr;
        logic [2:0]  fmt;
        logic [31:0] lo;
        logic [31:0] hi;

        rst = 1'b1; req_valid = 1'b0; req_addr = 32'h0; req_format = 3'b000;
        req_tag = '0; mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;
        rsp_ready = 1'b0;

        add_vec(32'h101, 3'b000, 5'h01, 0, 1, 0, 32'hFFFFFFAA, 1'b0);
        add_vec(32'h103, 3'b100, 5'h02, 0, 1, 0, 32'h00000088, 1'b0);
        add_vec(32'h102, 3'b001, 5'h03, 0, 1, 0, 32'hFFFF8899, 1'b0);
        add_vec(32'h100, 3'b101, 5'h04, 0, 1, 0, 32'h0000AABB, 1'b0);
        add_vec(32'h100, 3'b011, 5'h06, 0, 1, 0, 32'h00000000, 1'b1);
        add_vec(32'h100, 3'b010, 5'h1F, 4, 3, 0, 32'h8899AABB, 1'b0);
        add_vec(32'h102, 3'b101, 5'h0A, 0, 1, 3, 32'h00008899, 1'b0);
        add_vec(32'h200, 3'b111, 5'h0B, 0, 1, 1, 32'h00000000, 1'b1);
        add_vec(32'h200, 3'b110, 5'h0C, 0, 1, 0, 32'h00000000, 1'b1);
`ifdef MISALIGNED_LOAD_EN
        add_vec(32'h102, 3'b010, 5'h05, 0, 1, 0, 32'h33448899, 1'b0);
        add_vec(32'h103, 3'b001, 5'h07, 1, 2, 0, 32'h00004488, 1'b0);
        add_vec(32'hFFFFFFFE, 3'b010, 5'h11, 0, 1, 0, 32'h33448899, 1'b0);
        add_vec(32'h101, 3'b001, 5'h12, 0, 1, 0, 32'hFFFF99AA, 1'b0);
`else
        add_vec(32'h102, 3'b010, 5'h05, 0, 1, 0, 32'h00000000, 1'b1);
        add_vec(32'h103, 3'b001, 5'h07, 1, 2, 0, 32'h00000000, 1'b1);
        add_vec(32'hFFFFFFFE, 3'b010, 5'h11, 0, 1, 0, 32'h00000000, 1'b1);
        add_vec(32'h101, 3'b001, 5'h12, 0, 1, 0, 32'h00000000, 1'b1);
`endif

        // Reset state
        @(negedge clk);
        checkOutput("reset.req_ready", 32'(req_ready), 32'd1);
        checkOutput("reset.mem_req", 32'(mem_req), 32'd0);
        checkOutput("reset.mem_addr", mem_addr, 32'h0);
        checkOutput("reset.rsp_valid", 32'(rsp_valid), 32'd0);
        checkOutput("reset.rsp_data", rsp_data, 32'h0);
        checkOutput("reset.rsp_tag", 32'(rsp_tag), 32'd0);
        checkOutput("reset.rsp_except", 32'(rsp_except), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Directed table
        foreach (vecs[i]) begin
            modelLoad(vecs[i].addr, vecs[i].fmt, vecs[i].lo, vecs[i].hi, m_data, m_exc, m_reads);
            run_case($sformatf("vec%0d", i), vecs[i].addr, vecs[i].fmt, vecs[i].tag,
                     vecs[i].lo, vecs[i].hi, vecs[i].g, vecs[i].r, vecs[i].rdy,
                     vecs[i].exp_data, vecs[i].exp_exc, m_reads);
        end

        // Reset while waiting for read data, followed by a stale rvalid
        req_valid = 1'b1; req_addr = 32'h100; req_format = 3'b010; req_tag = 5'h15;
        @(negedge clk);
        req_valid = 1'b0;
        checkOutput("rstwait.mem_req", 32'(mem_req), 32'd1);
        mem_gnt = 1'b1;
        @(negedge clk);
        mem_gnt = 1'b0;
        rst = 1'b1;
        #1;
        checkOutput("rstwait.async_req_ready", 32'(req_ready), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'hDEADBEEF;
        @(negedge clk);
        mem_rvalid = 1'b0;
        for (int c = 0; c < 3; c++) begin
            checkOutput($sformatf("rstwait%0d.rsp_valid", c), 32'(rsp_valid), 32'd0);
            checkOutput($sformatf("rstwait%0d.req_ready", c), 32'(req_ready), 32'd1);
            checkOutput($sformatf("rstwait%0d.mem_req", c), 32'(mem_req), 32'd0);
            checkOutput($sformatf("rstwait%0d.mem_addr", c), mem_addr, 32'h0);
            checkOutput($sformatf("rstwait%0d.rsp_data", c), rsp_data, 32'h0);
            checkOutput($sformatf("rstwait%0d.rsp_tag", c), 32'(rsp_tag), 32'd0);
            checkOutput($sformatf("rstwait%0d.rsp_except", c), 32'(rsp_except), 32'd0);
            @(negedge clk);
        end

        // Randomized loads against the reference model
        for (int i = 0; i < 40; i++) begin
            addr = $urandom;
            if (i % 5 == 0) addr = 32'hFFFFFFFC | 32'($urandom_range(0, 3));
            fmt = 3'($urandom_range(0, 7));
            lo  = $urandom;
            hi  = $urandom;
            modelLoad(addr, fmt, lo, hi, m_data, m_exc, m_reads);
            run_case($sformatf("rand%0d", i), addr, fmt, TAG_W'($urandom), lo, hi,
                     $urandom_range(0, 3), $urandom_range(1, 3), $urandom_range(0, 2),
                     m_data, m_exc, m_reads);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
        $finish;
    end

endmodule
